inst_fetch_queue: RTL

- Instruction buffer between the fetch stage (I-cache return path) and the decode stage.
- Buffers fetched instruction words together with their PC and fetch-exception flag.
- Presents the oldest entry as instrD, pcD and adelD to the main decoder, first-word fall-through.
- Decouples I-cache latency from decode stalls; is emptied by pipeline flush (exception, eret, branch redirect).

---
 rtl/inst_fetch_queue.sv | 109 ++++++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: circular buffer of {adel, pc, instr} between the I-cache return path and decode.
// Latency: a pushed word reaches the head one cycle later (no bypass); head is first-word fall-through.
// Backpressure: full/almost_full advise fetch to stop; a push while full is dropped, a pop while empty is ignored.
module inst_fetch_queue #(
  parameter int DEPTH    = 8,  // power of two, at least 2
  parameter int AF_LEVEL = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push_valid,
  input  logic [31:0]              push_pc,
  input  logic [31:0]              push_instr,
  input  logic                     push_adel,
  output logic                     full,
  output logic                     almost_full,
  input  logic                     pop,
  output logic                     instrD_valid,
  output logic [31:0]              instrD,
  output logic [31:0]              pcD,
  output logic                     adelD,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // pc, instr and adel are stored as one word so they can never drift apart
  typedef struct packed {
    logic        adel;
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          push_acc;
  logic          pop_eff;
  entry_t        head;

  // Status and head outputs come straight from registered state
  always_comb begin
    full         = (count_q == CW'(DEPTH));
    almost_full  = (count_q >= CW'(AF_LEVEL));
    instrD_valid = (count_q != '0);
    count        = count_q;
    head         = mem_q[rd_ptr_q];
    instrD       = instrD_valid ? head.instr : 32'h0;
    pcD          = instrD_valid ? head.pc    : 32'h0;
    adelD        = instrD_valid ? head.adel  : 1'b0;
  end

  // Handshake qualification: full is the registered value, so a pop never frees room for a same-cycle push
  always_comb begin
    push_acc = push_valid && !full;
    pop_eff  = pop && instrD_valid;
  end

  // Next pointer/occupancy; flush empties the queue and overrides push and pop
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_eff)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_acc, pop_eff})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage write: an accepted push lands at wr_ptr unless a flush discards it
  always_comb begin
    mem_d = mem_q;
    if (push_acc && !flush) begin
      mem_d[wr_ptr_q] = '{adel: push_adel, pc: push_pc, instr: push_instr};
    end
  end

  // Control state register; reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is never reset; count gates what is visible
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
